// File: rtl/huedeon_pkg.sv
// Shared types and helpers for the huedeon raster back end: framebuffer geometry,
// address/colour widths, the queued pixel entry and RGB565 packing.
package huedeon_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    // Two full frames (front and back buffer) share the word address space.
    localparam int FB_WORDS  = 2 * FB_WIDTH * FB_HEIGHT;

    localparam int ADDR_W    = 18;
    localparam int RGB565_W  = 16;
    localparam int ENTRY_W   = ADDR_W + RGB565_W;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [RGB565_W-1:0] data;
    } pixel_entry_t;

    function automatic logic [RGB565_W-1:0] pack_rgb565(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/huedeon_sync_fifo.sv
// Single-clock FIFO with show-ahead head, wrap-bit pointers and occupancy count.
// Push while full is ignored unless a pop happens in the same cycle.
module huedeon_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic              wr_en_s;
    logic              rd_en_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rd_en_s = pop && !empty;
    // When full, the slot being written is the one popped this same cycle.
    assign wr_en_s = push && (!full || rd_en_s);
    assign level   = wr_ptr_r - rd_ptr_r;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/huedeon_pixel_writer.sv
// Packs raster pixels to RGB565, queues them and drains them to the framebuffer
// over a strobe/ack port. Define HUEDEON_PIXWR_BOUNDS_EN to drop addresses >= FB_LIMIT.
module huedeon_pixel_writer
    import huedeon_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ALMOST_MARGIN = 4,
    parameter int FB_LIMIT      = FB_WORDS
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr_enable,
    input  logic [17:0]              i_wr_address,
    input  logic [7:0]               i_r,
    input  logic [7:0]               i_g,
    input  logic [7:0]               i_b,
    input  logic                     i_clear_overflow,
    output logic                     o_mem_stb,
    output logic [17:0]              o_mem_addr,
    output logic [15:0]              o_mem_data,
    input  logic                     i_mem_ack,
    output logic                     o_busy,
    output logic                     o_almost_full,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W:0] LIMIT_C  = (ADDR_W+1)'(FB_LIMIT);
    localparam logic [LW-1:0]   DEPTH_C  = LW'(DEPTH);
    localparam logic [LW-1:0]   MARGIN_C = LW'(ALMOST_MARGIN);

    pixel_entry_t        in_entry_s;
    pixel_entry_t        head_s;
    logic                in_bounds_s;
    logic                accept_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                pop_s;
    logic                drop_s;
    logic [LW-1:0]       level_s;
    logic [LW-1:0]       free_s;

    logic                mem_stb_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [RGB565_W-1:0] mem_data_r;
    logic                overflow_r;

`ifdef HUEDEON_PIXWR_BOUNDS_EN
    assign in_bounds_s = ({1'b0, i_wr_address} < LIMIT_C);
`else
    // The limit is still referenced so the parameter stays visible in builds without the filter.
    logic unused_limit_s;
    assign unused_limit_s = ^LIMIT_C;
    assign in_bounds_s    = 1'b1;
`endif

    assign in_entry_s = {i_wr_address, pack_rgb565(i_r, i_g, i_b)};
    assign accept_s   = i_wr_enable && in_bounds_s;
    // Refill the output register whenever it is idle or its word is being accepted.
    assign pop_s      = !fifo_empty_s && (!mem_stb_r || i_mem_ack);
    assign drop_s     = accept_s && fifo_full_s && !pop_s;

    huedeon_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (accept_s),
        .pop     (pop_s),
        .wr_data (in_entry_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (level_s)
    );

    // Output register and strobe for the framebuffer handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_stb_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_data_r <= {RGB565_W{1'b0}};
        end else if (pop_s) begin
            mem_stb_r  <= 1'b1;
            mem_addr_r <= head_s.addr;
            mem_data_r <= head_s.data;
        end else if (i_mem_ack) begin
            mem_stb_r  <= 1'b0;
        end
    end

    // Sticky drop flag; a drop in the same cycle beats the clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (i_clear_overflow) begin
            overflow_r <= 1'b0;
        end
    end

    assign free_s        = DEPTH_C - level_s;
    assign o_almost_full = (free_s <= MARGIN_C);
    assign o_busy        = !fifo_empty_s || mem_stb_r;
    assign o_level       = level_s;
    assign o_mem_stb     = mem_stb_r;
    assign o_mem_addr    = mem_addr_r;
    assign o_mem_data    = mem_data_r;
    assign o_overflow    = overflow_r;

endmodule

// File: tb/tb_huedeon_pixel_writer.sv
// Directed bench for huedeon_pixel_writer: latency, fill/overflow, ack stall,
// full push+pop, reset mid-transfer and the address limit.
module tb_huedeon_pixel_writer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wr_enable;
    logic [17:0] i_wr_address;
    logic [7:0]  i_r;
    logic [7:0]  i_g;
    logic [7:0]  i_b;
    logic        i_clear_overflow;
    logic        o_mem_stb;
    logic [17:0] o_mem_addr;
    logic [15:0] o_mem_data;
    logic        i_mem_ack;
    logic        o_busy;
    logic        o_almost_full;
    logic        o_overflow;
    logic [4:0]  o_level;

    int checks = 0;
    int errors = 0;
    logic [17:0] wa_q[$];
    logic [15:0] wd_q[$];

    always #5 i_clk = ~i_clk;

    huedeon_pixel_writer #(
        .DEPTH         (16),
        .ALMOST_MARGIN (4),
        .FB_LIMIT      (153600)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_wr_enable      (i_wr_enable),
        .i_wr_address     (i_wr_address),
        .i_r              (i_r),
        .i_g              (i_g),
        .i_b              (i_b),
        .i_clear_overflow (i_clear_overflow),
        .o_mem_stb        (o_mem_stb),
        .o_mem_addr       (o_mem_addr),
        .o_mem_data       (o_mem_data),
        .i_mem_ack        (i_mem_ack),
        .o_busy           (o_busy),
        .o_almost_full    (o_almost_full),
        .o_overflow       (o_overflow),
        .o_level          (o_level)
    );

    // Record every completed framebuffer write.
    always @(posedge i_clk) begin
        if (!i_reset && o_mem_stb && i_mem_ack) begin
            wa_q.push_back(o_mem_addr);
            wd_q.push_back(o_mem_data);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [17:0] a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        i_wr_enable  = 1'b1;
        i_wr_address = a;
        i_r          = r;
        i_g          = g;
        i_b          = b;
    endtask

    initial begin
        int n;

        i_reset = 1'b1;
        i_wr_enable = 1'b0;
        i_wr_address = 18'd0;
        i_r = 8'd0;
        i_g = 8'd0;
        i_b = 8'd0;
        i_clear_overflow = 1'b0;
        i_mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_stb",   32'(o_mem_stb),     32'd0);
        chk("rst_addr",  32'(o_mem_addr),    32'd0);
        chk("rst_data",  32'(o_mem_data),    32'd0);
        chk("rst_busy",  32'(o_busy),        32'd0);
        chk("rst_afull", 32'(o_almost_full), 32'd0);
        chk("rst_ovf",   32'(o_overflow),    32'd0);
        chk("rst_level", 32'(o_level),       32'd0);

        // Single pixel, ack tied high
        i_reset = 1'b0;
        i_mem_ack = 1'b1;
        drive(18'h00140, 8'hFF, 8'h80, 8'h08);
        tick();
        i_wr_enable = 1'b0;
        chk("one_k1_stb",   32'(o_mem_stb), 32'd0);
        chk("one_k1_level", 32'(o_level),   32'd1);
        chk("one_k1_busy",  32'(o_busy),    32'd1);
        tick();
        chk("one_k2_stb",   32'(o_mem_stb),  32'd1);
        chk("one_k2_addr",  32'(o_mem_addr), 32'h00140);
        chk("one_k2_data",  32'(o_mem_data), 32'h0000FC01);
        chk("one_k2_level", 32'(o_level),    32'd0);
        tick();
        chk("one_k3_stb",    32'(o_mem_stb),   32'd0);
        chk("one_k3_busy",   32'(o_busy),      32'd0);
        chk("one_k3_writes", 32'(wa_q.size()), 32'd1);

        // 20 back-to-back pixels with ack held low
        i_mem_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(18'h01000 + 18'(i), 8'(i * 8), 8'd0, 8'd0);
            tick();
            if (i == 11) begin
                chk("fill11_level", 32'(o_level),       32'd11);
                chk("fill11_afull", 32'(o_almost_full), 32'd0);
            end
            if (i == 12) begin
                chk("fill12_level", 32'(o_level),       32'd12);
                chk("fill12_afull", 32'(o_almost_full), 32'd1);
            end
            if (i == 16) begin
                chk("fill16_ovf", 32'(o_overflow), 32'd0);
            end
        end
        i_wr_enable = 1'b0;
        chk("fill_level", 32'(o_level),       32'd16);
        chk("fill_ovf",   32'(o_overflow),    32'd1);
        chk("fill_afull", 32'(o_almost_full), 32'd1);
        chk("fill_stb",   32'(o_mem_stb),     32'd1);
        chk("fill_addr",  32'(o_mem_addr),    32'h01000);
        i_mem_ack = 1'b1;
        repeat (16) tick();
        chk("drain16_writes", 32'(wa_q.size()), 32'd17);
        tick();
        chk("drain17_writes", 32'(wa_q.size()), 32'd18);
        chk("drain_stb",      32'(o_mem_stb),   32'd0);
        chk("drain_busy",     32'(o_busy),      32'd0);
        for (int j = 0; j < 17; j++) begin
            chk($sformatf("drain_addr%0d", j), 32'(wa_q[1 + j]), 32'(18'h01000 + 18'(j)));
            chk($sformatf("drain_data%0d", j), 32'(wd_q[1 + j]), 32'(16'(j) << 11));
        end
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
        i_clear_overflow = 1'b1;
        tick();
        i_clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(o_overflow), 32'd0);

        // Ack stall for five cycles
        i_mem_ack = 1'b0;
        n = wa_q.size();
        drive(18'h02000, 8'h00, 8'hFC, 8'h00);
        tick();
        drive(18'h02001, 8'h00, 8'h00, 8'hF8);
        tick();
        i_wr_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_stb", i),  32'(o_mem_stb),  32'd1);
            chk($sformatf("stall%0d_addr", i), 32'(o_mem_addr), 32'h02000);
            chk($sformatf("stall%0d_data", i), 32'(o_mem_data), 32'h000007E0);
            tick();
        end
        chk("stall_nowrite", 32'(wa_q.size()), 32'(n));
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        chk("stall_next_stb",  32'(o_mem_stb),   32'd1);
        chk("stall_next_addr", 32'(o_mem_addr),  32'h02001);
        chk("stall_next_data", 32'(o_mem_data),  32'h0000001F);
        chk("stall_one_write", 32'(wa_q.size()), 32'(n + 1));
        chk("stall_wr_addr",   32'(wa_q[n]),     32'h02000);
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        chk("stall_end_stb",    32'(o_mem_stb),   32'd0);
        chk("stall_two_writes", 32'(wa_q.size()), 32'(n + 2));

        // Full FIFO: push together with ack, then a drop against a clear
        for (int i = 0; i < 17; i++) begin
            drive(18'h03000 + 18'(i), 8'd0, 8'd0, 8'd0);
            tick();
        end
        i_wr_enable = 1'b0;
        chk("full_level", 32'(o_level),    32'd16);
        chk("full_ovf",   32'(o_overflow), 32'd0);
        chk("full_stb",   32'(o_mem_stb),  32'd1);
        drive(18'h03011, 8'd0, 8'd0, 8'd0);
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        chk("pushpop_level", 32'(o_level),    32'd16);
        chk("pushpop_ovf",   32'(o_overflow), 32'd0);
        chk("pushpop_addr",  32'(o_mem_addr), 32'h03001);
        drive(18'h03012, 8'd0, 8'd0, 8'd0);
        i_clear_overflow = 1'b1;
        tick();
        i_wr_enable = 1'b0;
        i_clear_overflow = 1'b0;
        chk("drop_clr_ovf",   32'(o_overflow), 32'd1);
        chk("drop_clr_level", 32'(o_level),    32'd16);

        // Reset mid-transfer with eight queued
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rst2_level", 32'(o_level),    32'd0);
        chk("rst2_ovf",   32'(o_overflow), 32'd0);
        for (int i = 0; i < 9; i++) begin
            drive(18'h04000 + 18'(i), 8'd0, 8'd0, 8'd0);
            tick();
        end
        i_wr_enable = 1'b0;
        chk("pre_rst_stb",   32'(o_mem_stb), 32'd1);
        chk("pre_rst_level", 32'(o_level),   32'd8);
        n = wa_q.size();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rst3_stb",   32'(o_mem_stb), 32'd0);
        chk("rst3_level", 32'(o_level),   32'd0);
        chk("rst3_busy",  32'(o_busy),    32'd0);
        i_mem_ack = 1'b1;
        repeat (5) tick();
        chk("rst3_nowrites", 32'(wa_q.size()), 32'(n));
        chk("rst3_stb_idle", 32'(o_mem_stb),   32'd0);

        // Framebuffer limit boundary
        n = wa_q.size();
        drive(18'd153599, 8'd0, 8'd0, 8'd0);
        tick();
        drive(18'd153600, 8'd0, 8'd0, 8'd0);
        tick();
        i_wr_enable = 1'b0;
        repeat (4) tick();
        chk("bound_first_addr", 32'(wa_q[n]),  32'd153599);
        chk("bound_ovf",        32'(o_overflow), 32'd0);
        chk("bound_level",      32'(o_level),    32'd0);
`ifdef HUEDEON_PIXWR_BOUNDS_EN
        chk("bound_writes", 32'(wa_q.size()), 32'(n + 1));
`else
        chk("bound_writes",     32'(wa_q.size()), 32'(n + 2));
        chk("bound_second_addr", 32'(wa_q[n + 1]), 32'd153600);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/huedeon_pixel_writer.md
# huedeon_pixel_writer

Downstream stage of the triangle raster engine. Accepts one shaded pixel per cycle (framebuffer word address plus 8-bit R/G/B), packs it to RGB565 and queues it in a small FIFO. Drains the FIFO onto the framebuffer SRAM port through a strobe/acknowledge handshake. Decouples the raster engine, which cannot stall, from memory wait states, and reports drained/overflow status back to the GPU status register.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- ALMOST_MARGIN, 4, o_almost_full asserts when free entries <= ALMOST_MARGIN.
- FB_LIMIT, 153600, first invalid word address; used only with bounds check.

Ports:
- i_clk  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_wr_enable  in  1  pixel valid this cycle.
- i_wr_address  in  18  framebuffer word address.
- i_r / i_g / i_b  in  8 each  pixel colour.
- i_clear_overflow  in  1  clears sticky overflow.
- o_mem_stb  out  1  write request valid.
- o_mem_addr  out  18  write address.
- o_mem_data  out  16  RGB565 word.
- i_mem_ack  in  1  write accepted this cycle.
- o_busy  out  1  FIFO non-empty or o_mem_stb high.
- o_almost_full  out  1  see ALMOST_MARGIN.
- o_overflow  out  1  sticky: a pixel was dropped.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy, output register excluded.

## Operation
- Pack: data = {r[7:3], g[7:2], b[7:3]}. Entry = {addr, data}, 34 bits.
- Push when i_wr_enable. If FIFO full and no pop in the same cycle, the pixel is dropped and o_overflow sets.
- Push and pop in the same cycle while full: both happen, and the level is unchanged.
- Output stage is a register holding one entry. o_mem_stb, o_mem_addr and o_mem_data are all registered.
- Output register loads the FIFO head (pop) when FIFO is non-empty and (o_mem_stb == 0 or i_mem_ack == 1).
- After load, o_mem_stb = 1. If no load occurs when ack arrives, o_mem_stb = 0.
- Handshake:
  - o_mem_addr and o_mem_data stay stable while o_mem_stb && !i_mem_ack.
  - A transfer completes in the cycle where both are high.
  - i_mem_ack while o_mem_stb == 0 is ignored.
- o_overflow:
  - Set takes priority over i_clear_overflow in the same cycle.
  - Cleared only by i_clear_overflow or reset.
- o_level decrements on pop and increments on an accepted push. Occupancy wrap is impossible because push is blocked when full.

## Timing
- Reset values: o_mem_stb 0, o_mem_addr 0, o_mem_data 0, o_busy 0, o_almost_full 0, o_overflow 0, o_level 0. FIFO pointers are 0.
- Reset mid-transfer: o_mem_stb drops in the next cycle and all queued pixels are discarded.
- Latency, empty FIFO:
  - Pixel sampled at edge k.
  - Head visible in cycle k+1, loaded at edge k+1.
  - o_mem_stb high in cycle k+2.
- Throughput: 1 pixel/cycle when i_mem_ack is held high.
- o_almost_full and o_busy are combinational from registered state, with no input-to-output path.

## Configuration
- Macro: HUEDEON_PIXWR_BOUNDS_EN.
- Defined: pixels with i_wr_address >= FB_LIMIT are discarded before the FIFO. They do not change o_level and do not set o_overflow.
- Undefined: all pixels are queued regardless of address, and FB_LIMIT is unused.

## Structure
- Shared package huedeon_pkg holds:
  - FB_WIDTH = 320 and FB_HEIGHT = 240.
  - Address width 18 and RGB565 width 16.
  - The pixel entry typedef {addr, data}.
  - The pack_rgb565 function.
- One sub-module: huedeon_sync_fifo.
  - Parameterised width and depth.
  - Push/pop/full/empty/level, synchronous active-high reset.
  - Pointers with an extra wrap bit.
- Top level holds packing, the bounds filter, the output register and the overflow flag.

## Test plan
- Single pixel (addr 0x00140, r=0xFF, g=0x80, b=0x08), i_mem_ack tied 1 -> o_mem_stb high exactly one cycle, two cycles after input, data 0xFC01, addr 0x00140; o_busy then 0.
- 20 back-to-back pixels, DEPTH 16, i_mem_ack 0 -> o_level reaches 16 and o_overflow sets. Release ack -> 17 writes in order (16 FIFO entries + 1 output register); the remaining 3 pixels are lost.
- Ack stall: pixel held with ack low for 5 cycles -> addr/data stable for all 5 cycles, single completion, next entry presented the cycle after ack.
- Full FIFO, simultaneous push and ack -> o_level stays 16, o_overflow unchanged. i_clear_overflow with concurrent drop -> o_overflow remains 1.
- Reset asserted while o_mem_stb high with 8 queued -> next cycle o_mem_stb 0, o_level 0, o_busy 0, and no further writes.
- With HUEDEON_PIXWR_BOUNDS_EN, pixels at addr 153599 and 153600 -> only 153599 is written, and o_overflow stays 0.
